// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-line frontend.
// Autobaud support is compiled in when UART_AUTOBAUD_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_START,
    MEASURE,
    FINISH
  } ab_state_t;

  localparam logic [7:0] AB_SYNC_CHAR = 8'h55;
  localparam int         AB_EDGES     = 5;
  localparam int         AB_RND       = 8;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync_filter.sv
// Two-flop synchroniser, 3-tap majority glitch filter and
// registered falling-edge detect for the raw RX line.
module uart_rx_sync_filter
  import uart_pkg::*;
#(
  parameter logic SYNC_INIT = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_o,
  output logic fall_o
);

  logic       s1_q, s2_q;
  logic [2:0] f_q;
  logic       rx_q, prev_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= SYNC_INIT;
      s2_q   <= SYNC_INIT;
      f_q    <= {3{SYNC_INIT}};
      rx_q   <= SYNC_INIT;
      prev_q <= SYNC_INIT;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      f_q    <= {f_q[1:0], s2_q};
      rx_q   <= maj3(f_q);
      prev_q <= rx_q;
      fall_q <= prev_q & ~rx_q;
    end
  end

  assign rx_o   = rx_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// RX line conditioning plus optional 0x55 autobaud measurement.
// Define UART_AUTOBAUD_EN to compile in the autobaud engine.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter logic SYNC_INIT = 1'b1,
  parameter int   AB_CNT_W  = 20
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        RX,
  output logic        rx_o,
  output logic        fall_o,
  input  logic        ab_start,
  output logic        ab_busy,
  output logic        ab_done,
  output logic        ab_err,
  output logic [15:0] ab_div
);

  uart_rx_sync_filter #(
    .SYNC_INIT(SYNC_INIT)
  ) u_filt (
    .clk_i (Clk),
    .rst_ni(Rst_n),
    .rx_i  (RX),
    .rx_o  (rx_o),
    .fall_o(fall_o)
  );

`ifdef UART_AUTOBAUD_EN

  localparam logic [2:0] LAST_EDGE = 3'(AB_EDGES - 1);

  ab_state_t state_q, state_d;

  logic [AB_CNT_W-1:0] tot_q, tot_d;
  logic [AB_CNT_W-1:0] int_q, int_d;
  logic [AB_CNT_W-1:0] ref_q, ref_d;
  logic [2:0]          edge_q, edge_d;
  logic                err_q, err_d;
  logic [15:0]         div_q, div_d;

  logic [AB_CNT_W:0]   div_sum;
  logic [15:0]         div_calc;
  logic [AB_CNT_W-1:0] diff, tol;
  logic                tot_max, int_bad, fin_err;

  assign div_sum  = {1'b0, tot_q} + (AB_CNT_W+1)'(AB_RND);
  assign div_calc = 16'(div_sum >> 4);
  assign diff     = (int_q >= ref_q) ? (int_q - ref_q)
                                     : (ref_q - int_q);
  assign tol      = ref_q >> 2;
  assign int_bad  = diff > tol;
  assign tot_max  = &tot_q;
  assign fin_err  = err_q | (div_calc == 16'd0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      tot_q   <= '0;
      int_q   <= '0;
      ref_q   <= '0;
      edge_q  <= '0;
      err_q   <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      int_q   <= int_d;
      ref_q   <= ref_d;
      edge_q  <= edge_d;
      err_q   <= err_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (ab_start) state_d = ARM;
      ARM:        if (rx_o) state_d = WAIT_START;
      WAIT_START: if (fall_o) state_d = MEASURE;
      MEASURE: begin
        if (tot_max)
          state_d = FINISH;
        else if (fall_o && edge_q == LAST_EDGE)
          state_d = FINISH;
      end
      FINISH:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Timeout takes priority over a coincident edge.
  always_comb begin
    tot_d  = tot_q;
    int_d  = int_q;
    ref_d  = ref_q;
    edge_d = edge_q;
    err_d  = err_q;
    div_d  = div_q;
    unique case (state_q)
      WAIT_START: begin
        if (fall_o) begin
          tot_d  = '0;
          int_d  = '0;
          edge_d = 3'd1;
          err_d  = 1'b0;
        end
      end
      MEASURE: begin
        tot_d = tot_max ? tot_q : tot_q + 1'b1;
        int_d = int_q + 1'b1;
        if (tot_max) begin
          err_d = 1'b1;
        end else if (fall_o) begin
          if (edge_q == 3'd1)
            ref_d = int_q;
          else if (int_bad)
            err_d = 1'b1;
          int_d  = '0;
          edge_d = edge_q + 3'd1;
        end
      end
      FINISH: if (!fin_err) div_d = div_calc;
      default: ;
    endcase
  end

  always_comb begin
    ab_busy = (state_q == ARM) || (state_q == WAIT_START)
           || (state_q == MEASURE);
    ab_done = (state_q == FINISH);
    ab_err  = ab_done & fin_err;
    ab_div  = (ab_done && !fin_err) ? div_calc : div_q;
  end

`else

  logic ab_unused;
  localparam int AB_UNUSED_W = AB_CNT_W;

  assign ab_unused = ab_start;
  assign ab_busy   = 1'b0;
  assign ab_done   = 1'b0;
  assign ab_err    = 1'b0;
  assign ab_div    = 16'h0000;

`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: filter latency, glitch
// rejection and (when UART_AUTOBAUD_EN is defined) autobaud results.
module tb_uart_rx_frontend;

  localparam int CW = 12;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        RX;
  logic        rx_o;
  logic        fall_o;
  logic        ab_start;
  logic        ab_busy;
  logic        ab_done;
  logic        ab_err;
  logic [15:0] ab_div;

  always #5 Clk = ~Clk;

  uart_rx_frontend #(
    .SYNC_INIT(1'b1),
    .AB_CNT_W (CW)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .RX      (RX),
    .rx_o    (rx_o),
    .fall_o  (fall_o),
    .ab_start(ab_start),
    .ab_busy (ab_busy),
    .ab_done (ab_done),
    .ab_err  (ab_err),
    .ab_div  (ab_div)
  );

  typedef struct {
    logic        err;
    logic [15:0] div;
  } exp_t;

  exp_t sbq[$];
  logic rxh[$];

  int   checks = 0;
  int   failures = 0;
  int   fall_cnt = 0;
  int   low_cnt = 0;
  int   done_cnt = 0;
  logic ab_seen = 1'b0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge Clk) if (cmp_en) rxh.push_back(RX);

  // Monitor: event counters, rx_o latency model, autobaud scoreboard.
  always @(negedge Clk) begin
    exp_t e;
    if (fall_o === 1'b1) fall_cnt++;
    if (rx_o === 1'b0) low_cnt++;
    if (ab_busy !== 1'b0 || ab_done !== 1'b0 || ab_err !== 1'b0
        || ab_div !== 16'h0)
      ab_seen = 1'b1;
    if (ab_done === 1'b1) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done err=%0b div=%0d", ab_err, ab_div);
      end else begin
        e = sbq.pop_front();
        chk("ab_err", {31'b0, ab_err}, {31'b0, e.err});
        chk("ab_div", {16'b0, ab_div}, {16'b0, e.div});
        chk("busy_at_done", {31'b0, ab_busy}, 32'd0);
      end
    end
    if (cmp_en && rxh.size() >= 5) begin
      chk("rx_latency", {31'b0, rx_o}, {31'b0, rxh[rxh.size()-5]});
      void'(rxh.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input int p);
    RX = 1'b0;
    repeat (p) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (p) @(negedge Clk);
    end
    RX = 1'b1;
    repeat (p) @(negedge Clk);
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL ab_done_timeout pending=%0d", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    ab_start = 1'b1;
    @(negedge Clk);
    ab_start = 1'b0;
  endtask

  initial begin
    int bl, bf, bd;
    Rst_n    = 1'b0;
    RX       = 1'b0;
    ab_start = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_rx_o", {31'b0, rx_o}, 32'd1);
    chk("rst_fall_o", {31'b0, fall_o}, 32'd0);
    chk("rst_busy", {31'b0, ab_busy}, 32'd0);
    chk("rst_div", {16'b0, ab_div}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (4) @(posedge Clk);
    #1 chk("rx_edge4", {31'b0, rx_o}, 32'd1);
    @(posedge Clk);
    #1 chk("rx_edge5", {31'b0, rx_o}, 32'd0);
    @(negedge Clk);
    RX = 1'b1;
    repeat (10) @(negedge Clk);

    #1;
    bl = low_cnt;
    bf = fall_cnt;
    @(negedge Clk);
    RX = 1'b0;
    @(negedge Clk);
    RX = 1'b1;
    repeat (10) @(negedge Clk);
    #1;
    chk("glitch1_low", low_cnt - bl, 32'd0);
    chk("glitch1_fall", fall_cnt - bf, 32'd0);

    bl = low_cnt;
    bf = fall_cnt;
    @(negedge Clk);
    RX = 1'b0;
    repeat (2) @(negedge Clk);
    RX = 1'b1;
    repeat (10) @(negedge Clk);
    #1;
    chk("pulse2_low", low_cnt - bl, 32'd2);
    chk("pulse2_fall", fall_cnt - bf, 32'd1);

    @(negedge Clk);
    bf = fall_cnt;
    rxh.delete();
    cmp_en = 1'b1;
    send_byte(8'h55, 12);
    repeat (6) @(negedge Clk);
    cmp_en = 1'b0;
    #1 chk("sync_falls", fall_cnt - bf, 32'd5);

`ifdef UART_AUTOBAUD_EN
    bd = done_cnt;
    sbq.push_back('{1'b0, 16'd6});
    pulse_start();
    #1 chk("busy_after_start", {31'b0, ab_busy}, 32'd1);
    repeat (3) @(negedge Clk);
    ab_start = 1'b1;
    @(negedge Clk);
    ab_start = 1'b0;
    send_byte(8'h55, 12);
    wait_sb(200);
    repeat (20) @(negedge Clk);
    #1 chk("one_done", done_cnt - bd, 32'd1);

    sbq.push_back('{1'b0, 16'd122});
    pulse_start();
    send_byte(8'h55, 243);
    wait_sb(300);

    sbq.push_back('{1'b1, 16'd122});
    pulse_start();
    send_byte(8'h33, 12);
    send_byte(8'h33, 12);
    wait_sb(6000);
    repeat (2) @(negedge Clk);
    #1 chk("div_hold", {16'b0, ab_div}, 32'd122);

    sbq.push_back('{1'b1, 16'd122});
    pulse_start();
    @(negedge Clk);
    RX = 1'b0;
    repeat (12) @(negedge Clk);
    RX = 1'b1;
    wait_sb(6000);

    pulse_start();
    RX = 1'b0;
    repeat (12) @(negedge Clk);
    RX = 1'b1;
    repeat (12) @(negedge Clk);
    RX = 1'b0;
    repeat (12) @(negedge Clk);
    RX = 1'b1;
    repeat (20) @(negedge Clk);
    #1 chk("busy_mid", {31'b0, ab_busy}, 32'd1);
    bd = done_cnt;
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, ab_busy}, 32'd0);
    chk("rst_mid_div", {16'b0, ab_div}, 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (100) @(negedge Clk);
    #1;
    chk("rst_no_done", done_cnt - bd, 32'd0);
    chk("rst_busy_low", {31'b0, ab_busy}, 32'd0);
`else
    pulse_start();
    send_byte(8'h55, 12);
    repeat (20) @(negedge Clk);
    #1 chk("ab_quiet", {31'b0, ab_seen}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
